// File: rtl/conv_loop_sched_if.sv
// Control and buffer-access bundle between the convolution loop sequencer and its datapath.
// The sequencer side (master) drives the read addresses and strobes; the datapath side (slave) drives start.
interface conv_loop_sched_if #(
    parameter int unsigned AW = 16
);
    logic          start;
    logic          busy;
    logic          done;
    logic          in_ena;
    logic          w_ena;
    logic [AW-1:0] ifm_addr;
    logic [AW-1:0] weight_addr;
    logic          acc_first;
    logic          out_we;
    logic [AW-1:0] out_addr;

    modport master (
        input  start,
        output busy, done, in_ena, w_ena, ifm_addr, weight_addr,
        output acc_first, out_we, out_addr
    );

    modport slave (
        output start,
        input  busy, done, in_ena, w_ena, ifm_addr, weight_addr,
        input  acc_first, out_we, out_addr
    );
endinterface

// File: rtl/conv_loop_sched.sv
// Convolution loop-nest sequencer: walks m,r,c,n,i,j issuing one ifm/weight read per cycle and
// emits delay-aligned accumulator-load and output-write strobes under a start/busy/done handshake.
module conv_loop_sched #(
    parameter int unsigned M        = 4,
    parameter int unsigned NG       = 4,
    parameter int unsigned R        = 8,
    parameter int unsigned C        = 8,
    parameter int unsigned K        = 3,
    parameter int unsigned PIPE_LAT = 3,
    parameter int unsigned AW       = 16
) (
    input logic clk,
    input logic rst,
    conv_loop_sched_if.master bus
);
    localparam int unsigned IH = R + K - 1;
    localparam int unsigned IW = C + K - 1;
    localparam int unsigned DL = PIPE_LAT + 2;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t state, state_nx;

    logic [7:0] m_q, r_q, c_q, n_q;
    logic [3:0] i_q, j_q;
    logic       issue, done_c, final_term, first_c, last_c, pipe_empty;
    logic       j_wrap, i_wrap, n_wrap, c_wrap, r_wrap, m_wrap;
    logic [AW-1:0] nidx_c;

    logic [DL-1:0]       vld;
    logic [DL-1:0]       last_d;
    logic [PIPE_LAT:0]   first_d;
    logic [AW-1:0]       nidx_d [DL-1];
    logic [AW-1:0]       ifm_addr_q, weight_addr_q, out_addr_q;

    assign j_wrap = (32'(j_q) == K - 1);
    assign i_wrap = (32'(i_q) == K - 1);
    assign n_wrap = (32'(n_q) == NG - 1);
    assign c_wrap = (32'(c_q) == C - 1);
    assign r_wrap = (32'(r_q) == R - 1);
    assign m_wrap = (32'(m_q) == M - 1);

    assign final_term = m_wrap && r_wrap && c_wrap && n_wrap && i_wrap && j_wrap;
    assign first_c    = (n_q == '0) && (i_q == '0) && (j_q == '0);
    assign last_c     = n_wrap && i_wrap && j_wrap;
    assign nidx_c     = AW'(32'(m_q) * R * C + 32'(r_q) * C + 32'(c_q));
    assign pipe_empty = (vld == '0);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // The first term is issued in the accepting IDLE cycle so its registered read appears
    // in the first busy cycle; DRAIN lasts until the write strobe has left the delay line.
    always_comb begin
        state_nx = state;
        issue    = 1'b0;
        done_c   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    issue    = 1'b1;
                    state_nx = final_term ? DRAIN : RUN;
                end
            end
            RUN: begin
                issue = 1'b1;
                if (final_term) state_nx = DRAIN;
            end
            DRAIN: begin
                if (pipe_empty) begin
                    done_c   = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || !issue) begin
            m_q <= '0;
            r_q <= '0;
            c_q <= '0;
            n_q <= '0;
            i_q <= '0;
            j_q <= '0;
        end else begin
            j_q <= j_wrap ? '0 : j_q + 4'd1;
            if (j_wrap) begin
                i_q <= i_wrap ? '0 : i_q + 4'd1;
                if (i_wrap) begin
                    n_q <= n_wrap ? '0 : n_q + 8'd1;
                    if (n_wrap) begin
                        c_q <= c_wrap ? '0 : c_q + 8'd1;
                        if (c_wrap) begin
                            r_q <= r_wrap ? '0 : r_q + 8'd1;
                            if (r_wrap) m_q <= m_wrap ? '0 : m_q + 8'd1;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld           <= '0;
            first_d       <= '0;
            last_d        <= '0;
            ifm_addr_q    <= '0;
            weight_addr_q <= '0;
            out_addr_q    <= '0;
            for (int unsigned k = 0; k < DL - 1; k++) nidx_d[k] <= '0;
        end else begin
            vld     <= {vld[DL-2:0], issue};
            first_d <= {first_d[PIPE_LAT-1:0], issue && first_c};
            last_d  <= {last_d[DL-2:0], issue && last_c};
            nidx_d[0] <= nidx_c;
            for (int unsigned k = 1; k < DL - 1; k++) nidx_d[k] <= nidx_d[k-1];
            if (issue) begin
                ifm_addr_q    <= AW'((32'(n_q) * IH + 32'(r_q) + 32'(i_q)) * IW
                                     + 32'(c_q) + 32'(j_q));
                weight_addr_q <= AW'(((32'(m_q) * NG + 32'(n_q)) * K + 32'(i_q)) * K
                                     + 32'(j_q));
            end
            // Loaded one stage early so the address lands together with out_we and then holds.
            if (vld[DL-2] && last_d[DL-2]) out_addr_q <= nidx_d[DL-2];
        end
    end

    assign bus.busy        = (state != IDLE);
    assign bus.done        = done_c;
    assign bus.in_ena      = vld[0];
    assign bus.w_ena       = vld[0];
    assign bus.ifm_addr    = ifm_addr_q;
    assign bus.weight_addr = weight_addr_q;
    assign bus.acc_first   = vld[PIPE_LAT] && first_d[PIPE_LAT];
    assign bus.out_we      = vld[DL-1] && last_d[DL-1];
    assign bus.out_addr    = out_addr_q;
endmodule
